// File: rtl/pjdl_pkg.sv
// -----------------------------------------------------------------------------
// pjdl_pkg
// Shared PJDL definitions for the transmit and receive engines:
//   - PJDL_TIME_W    : default width of timing values and phase counters
//   - PJDL_INIT_PADS : default number of sync pads sent at frame start
//   - pjdl_time_t    : timing value type at the default width
//   - tx_state_e     : transmit engine state encoding
// -----------------------------------------------------------------------------
package pjdl_pkg;

    localparam int PJDL_TIME_W    = 20;
    localparam int PJDL_INIT_PADS = 3;

    typedef logic [PJDL_TIME_W-1:0] pjdl_time_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREAMBLE  = 3'd1,
        ST_INIT_HIGH = 3'd2,
        ST_INIT_LOW  = 3'd3,
        ST_PAD_HIGH  = 3'd4,
        ST_PAD_LOW   = 3'd5,
        ST_BIT       = 3'd6,
        ST_WAIT      = 3'd7
    } tx_state_e;

endpackage

// File: rtl/pjdl_phase_timer.sv
// -----------------------------------------------------------------------------
// pjdl_phase_timer
// Loadable down-counter that times one bus phase of len_i cycles (0 acts as 1).
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : start a new phase; the next cycle is the phase's first cycle
//   len_i        : phase length in cycles
//   done_o       : current cycle is the last cycle of the phase
//   half_o       : current cycle is cycle len_i/2 of the phase (0-based)
// -----------------------------------------------------------------------------
module pjdl_phase_timer
    import pjdl_pkg::*;
#(
    parameter int Width = PJDL_TIME_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] len_i,
    output logic             done_o,
    output logic             half_o
);

    logic [Width-1:0] cnt_q, cnt_d;
    logic [Width-1:0] half_q, half_d;
    logic [Width-1:0] last_idx;

    // Counter holds "cycles remaining minus one", so a phase of N spans N cycles.
    assign last_idx = (len_i == '0) ? '0 : len_i - Width'(1);

    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        if (load_i) begin
            cnt_d  = last_idx;
            half_d = last_idx - (len_i >> 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            half_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end

    assign done_o = (cnt_q == '0);
    assign half_o = (cnt_q == half_q);

endmodule

// File: rtl/pjdl_tx_engine.sv
// -----------------------------------------------------------------------------
// pjdl_tx_engine
// Serialises PJDL words onto the single-wire bus: optional preamble, frame-init
// pads, then per word a sync pad followed by DataWidth bits, LSB first. A
// one-entry holding register allows back-to-back words without a WAIT gap.
// Optional build macro PJDL_TX_COLLISION_EN: readback in low phases aborts the
// frame on a detected collision.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   data_i/last_i/valid_i : word input, accepted on valid_i & ready_o
//   ready_o               : holding register empty
//   pjon_i                : bus readback
//   pjon_o, pjon_en_o     : pad drive value and driver enable
//   busy_o                : frame in progress
//   collision_o           : one-cycle pulse on collision abort
//   spec_*_i              : phase timings in clock cycles
// -----------------------------------------------------------------------------
module pjdl_tx_engine
    import pjdl_pkg::*;
#(
    parameter int DataWidth    = 8,
    parameter int NumFramePads = PJDL_INIT_PADS,
    parameter int TimingWidth  = PJDL_TIME_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DataWidth-1:0]   data_i,
    input  logic                   last_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   pjon_i,
    output logic                   pjon_o,
    output logic                   pjon_en_o,
    output logic                   busy_o,
    output logic                   collision_o,
    input  logic [TimingWidth-1:0] spec_preamble_i,
    input  logic [TimingWidth-1:0] spec_pad_i,
    input  logic [TimingWidth-1:0] spec_data_i,
    input  logic [TimingWidth-1:0] spec_acceptance_i
);

    localparam int BitCntW = $clog2(DataWidth + 1);
    localparam int PadCntW = $clog2(NumFramePads + 1);

    tx_state_e state_q, state_d;

    logic                   hold_full_q, hold_full_d;
    logic [DataWidth-1:0]   hold_data_q, hold_data_d;
    logic                   hold_last_q, hold_last_d;
    logic [DataWidth-1:0]   shift_q, shift_d;
    logic                   cur_last_q, cur_last_d;
    logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [PadCntW-1:0]     pad_cnt_q, pad_cnt_d;
    logic                   frame_start_q, frame_start_d;
    logic [TimingWidth-1:0] idle_cnt_q, idle_cnt_d;

    logic                   tmr_load, tmr_done, tmr_half;
    logic [TimingWidth-1:0] tmr_len;
    logic [TimingWidth-1:0] acc_need;
    logic                   accept, load_shift, frame_go, last_bit, abort;

    pjdl_phase_timer #(.Width(TimingWidth)) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (tmr_load),
        .len_i  (tmr_len),
        .done_o (tmr_done),
        .half_o (tmr_half)
    );

    assign acc_need = (spec_acceptance_i == '0) ? TimingWidth'(1) : spec_acceptance_i;
    assign accept   = valid_i & ~hold_full_q;
    assign last_bit = (bit_cnt_q == BitCntW'(DataWidth - 1));
    // idle_cnt_d already includes this cycle's readback sample.
    assign frame_go = (state_q == ST_IDLE) && hold_full_q && (idle_cnt_d >= acc_need);

`ifdef PJDL_TX_COLLISION_EN
    logic low_phase;
    logic collision_q;
    // While we drive low, a high readback at mid-phase means another node is driving.
    assign low_phase = (state_q == ST_INIT_LOW) || (state_q == ST_PAD_LOW) ||
                       ((state_q == ST_BIT) && !shift_q[0]);
    assign abort     = low_phase && tmr_half && pjon_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) collision_q <= 1'b0;
        else       collision_q <= abort;
    end
    assign collision_o = collision_q;
`else
    logic unused_half;
    assign unused_half = tmr_half;
    assign abort       = 1'b0;
    assign collision_o = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state + phase timer load ----------------
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_len  = spec_pad_i;
        case (state_q)
            ST_IDLE: if (frame_go) begin
                tmr_load = 1'b1;
                if (spec_preamble_i != '0) begin
                    state_d = ST_PREAMBLE;
                    tmr_len = spec_preamble_i;
                end else begin
                    state_d = ST_INIT_HIGH;
                end
            end
            ST_PREAMBLE: if (tmr_done) begin
                tmr_load = 1'b1;
                state_d  = frame_start_q ? ST_INIT_HIGH : ST_PAD_HIGH;
            end
            ST_INIT_HIGH: if (tmr_done) begin
                tmr_load = 1'b1;
                tmr_len  = spec_data_i;
                state_d  = ST_INIT_LOW;
            end
            ST_INIT_LOW: if (tmr_done) begin
                tmr_load = 1'b1;
                state_d  = (pad_cnt_q == PadCntW'(NumFramePads - 1)) ? ST_PAD_HIGH : ST_INIT_HIGH;
            end
            ST_PAD_HIGH: if (tmr_done) begin
                tmr_load = 1'b1;
                tmr_len  = spec_data_i;
                state_d  = ST_PAD_LOW;
            end
            ST_PAD_LOW: if (tmr_done) begin
                tmr_load = 1'b1;
                tmr_len  = spec_data_i;
                state_d  = ST_BIT;
            end
            ST_BIT: if (tmr_done) begin
                tmr_load = 1'b1;
                tmr_len  = spec_data_i;
                if (last_bit) begin
                    tmr_len = spec_pad_i;
                    if (cur_last_q)       state_d = ST_IDLE;
                    else if (hold_full_q) state_d = ST_PAD_HIGH;
                    else                  state_d = ST_WAIT;
                end
            end
            ST_WAIT: if (hold_full_q) begin
                tmr_load = 1'b1;
                state_d  = ST_PAD_HIGH;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pjon_en_o = 1'b1;
        pjon_o    = 1'b0;
        busy_o    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:                              pjon_en_o = 1'b0;
            ST_PREAMBLE, ST_INIT_HIGH, ST_PAD_HIGH: pjon_o  = 1'b1;
            ST_BIT:                               pjon_o    = shift_q[0];
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    // Holding register drains into the shift register on every PAD_HIGH entry.
    assign load_shift = (state_d == ST_PAD_HIGH) && (state_q != ST_PAD_HIGH);

    always_comb begin
        hold_full_d   = hold_full_q;
        hold_data_d   = hold_data_q;
        hold_last_d   = hold_last_q;
        shift_d       = shift_q;
        cur_last_d    = cur_last_q;
        bit_cnt_d     = bit_cnt_q;
        pad_cnt_d     = pad_cnt_q;
        frame_start_d = frame_start_q;
        idle_cnt_d    = '0;

        if (state_q == ST_IDLE && !pjon_i)
            idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + TimingWidth'(1);

        if (load_shift) hold_full_d = 1'b0;
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = data_i;
            hold_last_d = last_i;
        end
        // A collision drops the whole frame, including anything queued behind it.
        if (abort) hold_full_d = 1'b0;

        if (load_shift) begin
            shift_d    = hold_data_q;
            cur_last_d = hold_last_q;
            bit_cnt_d  = '0;
        end else if (state_q == ST_BIT && tmr_done) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end

        if (state_q == ST_IDLE)
            pad_cnt_d = '0;
        else if (state_q == ST_INIT_LOW && tmr_done)
            pad_cnt_d = pad_cnt_q + PadCntW'(1);

        if (state_q == ST_IDLE)
            frame_start_d = frame_go;
        else if (state_q == ST_INIT_LOW && state_d == ST_PAD_HIGH)
            frame_start_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_full_q   <= 1'b0;
            hold_data_q   <= '0;
            hold_last_q   <= 1'b0;
            shift_q       <= '0;
            cur_last_q    <= 1'b0;
            bit_cnt_q     <= '0;
            pad_cnt_q     <= '0;
            frame_start_q <= 1'b0;
            idle_cnt_q    <= '0;
        end else begin
            hold_full_q   <= hold_full_d;
            hold_data_q   <= hold_data_d;
            hold_last_q   <= hold_last_d;
            shift_q       <= shift_d;
            cur_last_q    <= cur_last_d;
            bit_cnt_q     <= bit_cnt_d;
            pad_cnt_q     <= pad_cnt_d;
            frame_start_q <= frame_start_d;
            idle_cnt_q    <= idle_cnt_d;
        end
    end

    assign ready_o = ~hold_full_q;

endmodule

// File: tb/tb_pjdl_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_pjdl_tx_engine
// Drives an 8-bit and a 9-bit pjdl_tx_engine; the expected bus waveform of each
// frame is rebuilt from the phase rules (preamble, init pads, sync pad, bits)
// and compared cycle by cycle. Build macro PJDL_TX_COLLISION_EN selects the
// collision-abort scenario instead of the readback-noise scenario.
// -----------------------------------------------------------------------------
module tb_pjdl_tx_engine;

    localparam int TW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i, pjon_i;
    logic [TW-1:0] pre, pad, dat, acc;

    logic [7:0] data8;
    logic       last8, valid8, ready8, o8, en8, busy8, coll8;
    logic [8:0] data9;
    logic       last9, valid9, ready9, o9, en9, busy9, coll9;

    pjdl_tx_engine #(.DataWidth(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data8), .last_i(last8), .valid_i(valid8),
        .ready_o(ready8), .pjon_i(pjon_i), .pjon_o(o8), .pjon_en_o(en8), .busy_o(busy8),
        .collision_o(coll8), .spec_preamble_i(pre), .spec_pad_i(pad), .spec_data_i(dat),
        .spec_acceptance_i(acc)
    );

    pjdl_tx_engine #(.DataWidth(9)) u_dut9 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data9), .last_i(last9), .valid_i(valid9),
        .ready_o(ready9), .pjon_i(pjon_i), .pjon_o(o9), .pjon_en_o(en9), .busy_o(busy9),
        .collision_o(coll9), .spec_preamble_i(pre), .spec_pad_i(pad), .spec_data_i(dat),
        .spec_acceptance_i(acc)
    );

    int checks = 0;
    int failures = 0;

    bit   sel;  // 0: 8-bit instance under test, 1: 9-bit instance
    logic en_s, o_s, busy_s, ready_s, coll_s;
    assign en_s    = sel ? en9    : en8;
    assign o_s     = sel ? o9     : o8;
    assign busy_s  = sel ? busy9  : busy8;
    assign ready_s = sel ? ready9 : ready8;
    assign coll_s  = sel ? coll9  : coll8;

    logic [9:0] feed_q[$];   // {last, data}
    logic [8:0] byte_q[$];
    bit         exp_q[$];    // expected pjon_o per cycle while enabled
    bit         will_acc, r_prev, noise;
    int         rises, falls;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then drive the next inputs.
    task automatic step();
        @(negedge clk);
        if (!r_prev && ready_s) rises++;
        if (r_prev && !ready_s) falls++;
        r_prev = ready_s;
        if (will_acc) void'(feed_q.pop_front());
        valid8 = 1'b0;
        valid9 = 1'b0;
        if (feed_q.size() != 0) begin
            data8 = feed_q[0][7:0];
            data9 = feed_q[0][8:0];
            last8 = feed_q[0][9];
            last9 = feed_q[0][9];
            if (sel) valid9 = 1'b1;
            else     valid8 = 1'b1;
        end
        will_acc = (sel ? valid9 : valid8) && ready_s;
        if (noise) pjon_i = 1'($urandom_range(0, 1));
    endtask

    // Expected waveform straight from the phase rules.
    function automatic void build_model(input int w);
        int pa, da;
        pa = (pad == '0) ? 1 : int'(pad);
        da = (dat == '0) ? 1 : int'(dat);
        exp_q.delete();
        repeat (int'(pre)) exp_q.push_back(1'b1);
        repeat (3) begin
            repeat (pa) exp_q.push_back(1'b1);
            repeat (da) exp_q.push_back(1'b0);
        end
        foreach (byte_q[b]) begin
            repeat (pa) exp_q.push_back(1'b1);
            repeat (da) exp_q.push_back(1'b0);
            for (int i = 0; i < w; i++)
                repeat (da) exp_q.push_back(byte_q[b][i]);
        end
    endfunction

    task automatic start_frame();
        foreach (byte_q[b]) feed_q.push_back({(b == byte_q.size() - 1), byte_q[b]});
        rises  = 0;
        falls  = 0;
        r_prev = ready_s;
    endtask

    task automatic wait_en(output int n);
        n = 0;
        while (!en_s && n < 500) begin
            step();
            n++;
        end
        chk("en_rise", 32'(en_s), 32'd1);
    endtask

    // Called with the current cycle being the first enabled one.
    task automatic check_wave(input string tag, input bit noisy);
        noise = noisy;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i != 0) step();
            chk(tag, 32'({coll_s, busy_s, en_s, o_s}), 32'({1'b0, 2'b11, exp_q[i]}));
        end
        noise  = 1'b0;
        pjon_i = 1'b0;
        step();
        chk("frame_end", 32'({busy_s, en_s, o_s}), 32'd0);
    endtask

    task automatic run_frame(input string tag, input int w, input bit noisy);
        int n;
        build_model(w);
        start_frame();
        wait_en(n);
        check_wave(tag, noisy);
        chk("ready_rises", 32'(rises), 32'(byte_q.size()));
        chk("ready_falls", 32'(falls), 32'(byte_q.size()));
    endtask

    initial begin
        int n, nb, w;
        bit noisy;
        rst_i = 1'b1; pjon_i = 1'b0; noise = 1'b0; sel = 1'b0; will_acc = 1'b0;
        valid8 = 1'b0; valid9 = 1'b0; last8 = 1'b0; last9 = 1'b0; data8 = '0; data9 = '0;
        pre = '0; pad = TW'(8); dat = TW'(4); acc = TW'(6);
        repeat (3) step();
        rst_i = 1'b0;
        step();

        chk("rst_ready8", 32'(ready8), 32'd1);
        chk("rst_ready9", 32'(ready9), 32'd1);
        chk("rst_outs8",  32'({o8, en8, busy8, coll8}), 32'd0);
        chk("rst_outs9",  32'({o9, en9, busy9, coll9}), 32'd0);

        // Single word, 80 busy cycles.
        byte_q = '{9'h0A5};
        run_frame("single", 8, 1'b0);

        // Back-to-back words with valid held: no WAIT gap, one set of init pads.
        byte_q = '{9'h001, 9'h002, 9'h003};
        run_frame("b2b", 8, 1'b0);

        // Acceptance: bus held high with a word pending, then released.
        pjon_i = 1'b1;
        byte_q = '{9'h05A};
        build_model(8);
        start_frame();
        repeat (20) step();
        chk("acc_blocked", 32'(en_s), 32'd0);
        pjon_i = 1'b0;
        n = 0;
        while (!en_s && n < 100) begin step(); n++; end
        chk("acc_delay", 32'(n), 32'd6);
        check_wave("acc_frame", 1'b0);

        // A one-cycle glitch restarts the idle count.
        byte_q = '{9'h03C};
        build_model(8);
        start_frame();
        pjon_i = 1'b1;
        repeat (10) step();
        pjon_i = 1'b0;
        repeat (3) step();
        pjon_i = 1'b1;
        step();
        pjon_i = 1'b0;
        chk("glitch_blocked", 32'(en_s), 32'd0);
        n = 0;
        while (!en_s && n < 100) begin step(); n++; end
        chk("glitch_delay", 32'(n), 32'd6);
        check_wave("glitch_frame", 1'b0);

        // Preamble of 10 high cycles.
        pre = TW'(10);
        byte_q = '{9'h081};
        run_frame("preamble", 8, 1'b0);
        pre = '0;

        // Nine-bit words.
        sel = 1'b1;
        r_prev = ready_s;
        byte_q = '{9'h1FF};
        run_frame("w9", 9, 1'b0);

        // Randomised frames on both widths.
        for (int t = 0; t < 10; t++) begin
            sel    = t[0];
            w      = sel ? 9 : 8;
            pre    = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(1, 12));
            pad    = TW'($urandom_range(0, 6));
            dat    = TW'($urandom_range(0, 5));
            acc    = TW'($urandom_range(0, 5));
            nb     = $urandom_range(1, 3);
            byte_q.delete();
            repeat (nb) byte_q.push_back(9'($urandom) & ((w == 9) ? 9'h1FF : 9'h0FF));
`ifdef PJDL_TX_COLLISION_EN
            noisy = 1'b0;
`else
            noisy = (t >= 5);  // readback is ignored during a frame
`endif
            run_frame("rand", w, noisy);
        end

        sel = 1'b0;
        pre = '0; pad = TW'(8); dat = TW'(4); acc = TW'(2);

`ifdef PJDL_TX_COLLISION_EN
        // Readback high at the midpoint of the second INIT_LOW.
        byte_q = '{9'h0FF};
        start_frame();
        wait_en(n);
        repeat (22) step();
        pjon_i = 1'b1;
        step();
        pjon_i = 1'b0;
        chk("coll_pulse", 32'(coll_s), 32'd1);
        chk("coll_outs",  32'({en_s, o_s, busy_s}), 32'd0);
        chk("coll_ready", 32'(ready_s), 32'd1);
        step();
        chk("coll_once",  32'(coll_s), 32'd0);
`endif

        // Reset in the middle of the data bits with a second word held.
        byte_q = '{9'h055, 9'h0AA};
        start_frame();
        wait_en(n);
        repeat (36 + 12 + 6) step();
        chk("pre_rst_busy", 32'(busy_s), 32'd1);
        rst_i = 1'b1;
        feed_q.delete();
        will_acc = 1'b0;
        step();
        chk("rst_mid_outs",  32'({en_s, o_s, busy_s, coll_s}), 32'd0);
        chk("rst_mid_ready", 32'(ready_s), 32'd1);
        rst_i = 1'b0;
        step();

        byte_q = '{9'h00F};
        run_frame("after_rst", 8, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
